md_unit_sched: RTL and testbench

- Sequencer for the shared HI/LO multiply/divide resource in the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo from E stage and runs multi-cycle operations with a down-counter.
- Commits results to HI/LO and exposes HI/LO for mfhi/mflo.
- Drives the D-stage stall when a decoding md instruction would collide with an in-flight or starting operation.

---
 rtl/md_unit_sched_pkg.sv | 34 +++
 rtl/md_unit_sched_if.sv | 30 +++
 rtl/md_unit_sched_arith.sv | 59 +++++
 rtl/md_unit_sched.sv | 113 +++++++++++
 tb/tb_md_unit_sched.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/md_unit_sched_pkg.sv
// md_defs: shared definitions for the HI/LO multiply/divide sequencer.
//   md_op_e    - 4-bit E-stage md operation encoding
//   md_state_e - sequencer FSM state encoding
//   hilo_t     - packed {hi, lo} result pair
//   is_start   - true for the multi-cycle ops (mult/multu/div/divu)
package md_defs;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MFHI  = 4'd5,
      MD_MFLO  = 4'd6,
      MD_MTHI  = 4'd7,
      MD_MTLO  = 4'd8
   } md_op_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } md_state_e;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
   } hilo_t;

   function automatic logic is_start(md_op_e op);
      return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/md_unit_sched_if.sv
// md_unit_sched_if: E/D-stage handshake bundle for the md sequencer.
//   E_MDOp, E_RData1, E_RData2 - operation and operands from E
//   D_isMD                     - D-stage instruction is md-class
//   Start, Busy, Stall_D       - sequencer status back to the pipeline
//   HI, LO                     - architectural HI/LO
// master: pipeline side (drives the op); slave: the sequencer.
interface md_unit_sched_if;
   import md_defs::*;

   md_op_e      E_MDOp;
   logic [31:0] E_RData1;
   logic [31:0] E_RData2;
   logic        D_isMD;
   logic        Start;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;
   logic        Stall_D;

   modport master (
      output E_MDOp, E_RData1, E_RData2, D_isMD,
      input  Start, Busy, HI, LO, Stall_D
   );

   modport slave (
      input  E_MDOp, E_RData1, E_RData2, D_isMD,
      output Start, Busy, HI, LO, Stall_D
   );

endinterface

// File: rtl/md_unit_sched_arith.sv
// md_arith: combinational result for mult/multu/div/divu.
//   op_i       - md operation
//   a_i, b_i   - operands (rs, rt)
//   res_o      - {hi, lo}: product, or {remainder, quotient}
//   div_zero_o - divisor is zero
// Signed divide goes through magnitudes so that -2^31 / -1 stays well defined
// (wraps to 0x80000000) and the quotient truncates toward zero.
module md_arith
   import md_defs::*;
(
   input  md_op_e      op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output hilo_t       res_o,
   output logic        div_zero_o
);

   logic        is_signed;
   logic        a_neg;
   logic        b_neg;
   logic [63:0] a_ext;
   logic [63:0] b_ext;
   logic [63:0] prod;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] quot;
   logic [31:0] rem;

   always_comb begin
      is_signed  = (op_i == MD_MULT) || (op_i == MD_DIV);
      a_neg      = is_signed & a_i[31];
      b_neg      = is_signed & b_i[31];

      // One 64x64 multiplier serves both: only the extension differs.
      a_ext      = {{32{a_neg}}, a_i};
      b_ext      = {{32{b_neg}}, b_i};
      prod       = a_ext * b_ext;

      a_mag      = a_neg ? (~a_i + 32'd1) : a_i;
      b_mag      = b_neg ? (~b_i + 32'd1) : b_i;
      div_zero_o = (b_i == 32'd0);
      q_mag      = div_zero_o ? 32'd0 : (a_mag / b_mag);
      r_mag      = div_zero_o ? 32'd0 : (a_mag % b_mag);

      // Quotient sign is the xor of operand signs; remainder follows the dividend.
      quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
      rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

      res_o      = '0;
      case (op_i)
         MD_MULT, MD_MULTU: res_o = prod;
         MD_DIV, MD_DIVU:   res_o = '{hi: rem, lo: quot};
         default:           res_o = '0;
      endcase
   end

endmodule

// File: rtl/md_unit_sched.sv
// md_unit_sched: sequencer for the shared HI/LO multiply/divide unit.
//   clk, reset - pipeline clock, synchronous active-high reset
//   md         - slave side of md_unit_sched_if:
//                E_MDOp/E_RData1/E_RData2 in, D_isMD in,
//                Start/Busy/Stall_D out, HI/LO out
// A mult/div starting in IDLE captures its result into pending registers at
// the start edge, then holds Busy for MULT_CYCLES/DIV_CYCLES cycles before
// committing pending to HI/LO. mthi/mtlo write directly in one cycle.
module md_unit_sched
   import md_defs::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input logic             clk,
   input logic             reset,
   md_unit_sched_if.slave  md
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   md_state_e   state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   hilo_t       pend_q, pend_d;
   logic        pend_dz_q, pend_dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   hilo_t       arith_res;
   logic        arith_div_zero;
   logic        start;
   logic        busy;
   logic        is_mult;
   logic        is_div;

   md_arith u_arith (
      .op_i       (md.E_MDOp),
      .a_i        (md.E_RData1),
      .b_i        (md.E_RData2),
      .res_o      (arith_res),
      .div_zero_o (arith_div_zero)
   );

   assign start   = is_start(md.E_MDOp);
   assign busy    = (state_q == RUN);
   assign is_mult = (md.E_MDOp == MD_MULT) || (md.E_MDOp == MD_MULTU);
   assign is_div  = (md.E_MDOp == MD_DIV) || (md.E_MDOp == MD_DIVU);

   assign md.Start   = start;
   assign md.Busy    = busy;
   assign md.HI      = hi_q;
   assign md.LO      = lo_q;
   assign md.Stall_D = (start | busy) & md.D_isMD;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_d    = pend_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               pend_d    = arith_res;
               pend_dz_d = is_div & arith_div_zero;
               cnt_d     = is_mult ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
               state_d   = RUN;
            end else if (md.E_MDOp == MD_MTHI) begin
               hi_d = md.E_RData1;
            end else if (md.E_MDOp == MD_MTLO) begin
               lo_d = md.E_RData1;
            end
         end
         RUN: begin
            // Ops arriving in E while running are ignored; Stall_D should have held them.
            if (cnt_q == CntW'(1)) begin
               cnt_d   = '0;
               state_d = IDLE;
               // Divide by zero still burns the full busy period but leaves HI/LO alone.
               if (!pend_dz_q) begin
                  hi_d = pend_q.hi;
                  lo_d = pend_q.lo;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pend_q    <= '0;
         pend_dz_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_q    <= pend_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

endmodule

// File: tb/tb_md_unit_sched.sv
// Bench for md_unit_sched: directed ops; expected HI/LO and busy length are
// queued at issue and checked by a monitor when the DUT commits.
module tb_md_unit_sched;
   import md_defs::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          busy_len;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   md_unit_sched_if md_if ();

   md_unit_sched #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .md    (md_if)
   );

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, req);
      end
   endtask

   task automatic drive(input md_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic ds);
      @(negedge clk);
      md_if.E_MDOp   = op;
      md_if.E_RData1 = a;
      md_if.E_RData2 = b;
      md_if.D_isMD   = ds;
   endtask

   // Multi-cycle op: checks Start/Stall_D on issue, every busy cycle and the first idle one.
   task automatic do_md(input string name, input md_op_e op, input logic [31:0] a,
                        input logic [31:0] b, input logic ds, input logic [31:0] hi,
                        input logic [31:0] lo, input int len);
      sb.push_back('{hi: hi, lo: lo, busy_len: len, name: name});
      m_hi = hi;
      m_lo = lo;
      drive(op, a, b, ds);
      #1;
      chk1({name, "_start"}, md_if.Start, 1'b1);
      chk1({name, "_stall_start"}, md_if.Stall_D, ds);
      for (int i = 0; i < len; i++) begin
         drive(MD_NONE, 32'd0, 32'd0, ds);
         #1;
         chk1({name, "_busy"}, md_if.Busy, 1'b1);
         chk1({name, "_stall_busy"}, md_if.Stall_D, ds);
      end
      drive(MD_NONE, 32'd0, 32'd0, ds);
      #1;
      chk1({name, "_busy_done"}, md_if.Busy, 1'b0);
      chk1({name, "_stall_done"}, md_if.Stall_D, 1'b0);
   endtask

   // mthi/mtlo for one cycle; caller drives the following cycle.
   task automatic do_mt(input string name, input md_op_e op, input logic [31:0] a);
      if (op == MD_MTHI) m_hi = a;
      else               m_lo = a;
      sb.push_back('{hi: m_hi, lo: m_lo, busy_len: 0, name: name});
      drive(op, a, 32'd0, 1'b0);
      #1;
      chk1({name, "_start"}, md_if.Start, 1'b0);
   endtask

   // Monitor: a commit is a Busy fall, or the edge that consumed an mthi/mtlo.
   initial begin
      int          run;
      md_op_e      op_e;
      logic        bb;
      logic        re;
      exp_t        e;
      run = 0;
      forever begin
         @(posedge clk);
         op_e = md_if.E_MDOp;
         bb   = md_if.Busy;
         re   = reset;
         #1;
         if (re) begin
            run = 0;
         end else begin
            if (md_if.Busy === 1'b1) run++;
            if ((bb === 1'b1 && md_if.Busy === 1'b0) ||
                (bb === 1'b0 && (op_e == MD_MTHI || op_e == MD_MTLO))) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_commit: got HI=%h LO=%h expected no commit",
                           md_if.HI, md_if.LO);
               end else begin
                  e = sb.pop_front();
                  chk({e.name, "_hi"}, md_if.HI, e.hi);
                  chk({e.name, "_lo"}, md_if.LO, e.lo);
                  chk({e.name, "_busy_len"}, 32'(run), 32'(e.busy_len));
               end
               run = 0;
            end
         end
      end
   end

   // The pipeline must never present an md op while the unit is running.
   always @(posedge clk) begin
      if (reset === 1'b0 && md_if.Busy === 1'b1) begin
         assert (md_if.E_MDOp == MD_NONE)
         else $error("protocol: md op %0d in E while busy", md_if.E_MDOp);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      reset          = 1'b1;
      md_if.E_MDOp   = MD_NONE;
      md_if.E_RData1 = 32'd0;
      md_if.E_RData2 = 32'd0;
      md_if.D_isMD   = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk1("rst_busy", md_if.Busy, 1'b0);
      chk("rst_hi", md_if.HI, 32'd0);
      chk("rst_lo", md_if.LO, 32'd0);
      chk1("rst_start", md_if.Start, 1'b0);
      chk1("rst_stall", md_if.Stall_D, 1'b0);

      do_md("mult",    MD_MULT,  32'hFFFFFFFF, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
      do_md("multu",   MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h00000001, 32'hFFFFFFFE, 5);
      do_md("div",     MD_DIV,   32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      do_md("divu",    MD_DIVU,  32'd7,        32'd2, 1'b0, 32'h00000001, 32'h00000003, 10);
      do_md("div_nb",  MD_DIV,   32'd7, 32'hFFFFFFFE, 1'b0, 32'h00000001, 32'hFFFFFFFD, 10);

      do_mt("mthi", MD_MTHI, 32'h12345678);
      do_mt("mtlo", MD_MTLO, 32'h9ABCDEF0);
      drive(MD_MFHI, 32'd0, 32'd0, 1'b1);
      #1;
      chk1("mfhi_start", md_if.Start, 1'b0);
      chk1("mfhi_stall", md_if.Stall_D, 1'b0);
      chk("mfhi_hi", md_if.HI, 32'h12345678);
      chk("mfhi_lo", md_if.LO, 32'h9ABCDEF0);

      do_mt("mthi_a", MD_MTHI, 32'hAAAAAAAA);
      do_mt("mtlo_a", MD_MTLO, 32'hAAAAAAAA);
      do_md("divu_zero", MD_DIVU, 32'd5, 32'd0, 1'b1, 32'hAAAAAAAA, 32'hAAAAAAAA, 10);

      // Reset on the third busy cycle of a mult discards it.
      drive(MD_MULT, 32'd3, 32'd4, 1'b0);
      #1;
      chk1("abort_start", md_if.Start, 1'b1);
      for (int i = 0; i < 3; i++) begin
         drive(MD_NONE, 32'd0, 32'd0, 1'b0);
         #1;
         chk1("abort_busy", md_if.Busy, 1'b1);
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      #1;
      chk1("abort_busy_low", md_if.Busy, 1'b0);
      chk("abort_hi", md_if.HI, 32'd0);
      chk("abort_lo", md_if.LO, 32'd0);
      repeat (8) @(negedge clk);
      #1;
      chk1("abort_late_busy", md_if.Busy, 1'b0);
      chk("abort_late_hi", md_if.HI, 32'd0);
      chk("abort_late_lo", md_if.LO, 32'd0);

      do_md("mult2", MD_MULT, 32'd6, 32'd7, 1'b1, 32'd0, 32'h0000002A, 5);

      repeat (2) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
